// File: rtl/crossfile_pkg.sv
// Shared types for the crossfile datapath: transaction payload and default FIFO depth.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package crossfile_pkg;

    localparam int FIFO_DEPTH = 4;

    // One transaction as carried between producers, the scheduler and the consumer.
    typedef struct packed {
        logic [3:0]  id;
        logic [27:0] data;
    } transaction_t;

endpackage

// File: rtl/crossfile_rr_scheduler_if.sv
// Handshake bundle between NUM_REQ producers, the scheduler and a single consumer.
// Latency: n/a (wires only).
// Backpressure: req_ready per requester, out_ready from the consumer.
// Ports: master = producer/consumer side, slave = scheduler side.
interface crossfile_rr_scheduler_if import crossfile_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = FIFO_DEPTH
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NUM_REQ-1:0]         req_valid;
    transaction_t [NUM_REQ-1:0] req_trans;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       out_valid;
    transaction_t               out_trans;
    logic                       out_ready;
    logic [CW-1:0]              count;
    logic                       full;
    logic                       empty;
    logic [IW-1:0]              grant_id;

    modport master (
        output req_valid, req_trans, out_ready,
        input  req_ready, out_valid, out_trans, count, full, empty, grant_id
    );

    modport slave (
        input  req_valid, req_trans, out_ready,
        output req_ready, out_valid, out_trans, count, full, empty, grant_id
    );

endinterface

// File: rtl/crossfile_rr_arbiter.sv
// Round-robin pick of one requester, scanning from ptr upward with wrap-around.
// Latency: purely combinational.
// Backpressure: en low forces gnt to zero; gnt_idx still reports the would-be winner.
// Ports: req (requests), ptr (highest-priority index), en (grant enable),
//        gnt (one-hot or zero), gnt_idx (winner index).
module crossfile_rr_arbiter #(
    parameter int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   k;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[IW'(k)]) begin
                found         = 1'b1;
                gnt_idx       = IW'(k);
                gnt[IW'(k)]   = en;
            end
        end
    end

endmodule

// File: rtl/crossfile_rr_scheduler.sv
// Round-robin merge of NUM_REQ producers into one DEPTH-entry ring buffer feeding a single consumer.
// Latency: accept -> out_valid is 1 cycle (no empty bypass).
// Backpressure: a requester is accepted only while the buffer has room or is popped in the same cycle.
// Ports: clk, rst (sync, active-low); bus.slave carries req_valid/req_trans/req_ready,
//        out_valid/out_trans/out_ready, count/full/empty and grant_id.
module crossfile_rr_scheduler import crossfile_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    crossfile_rr_scheduler_if.slave bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    transaction_t       mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      win;
    logic               full, empty, pop, push, can_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = !empty && bus.out_ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign can_push = !full || pop;
    assign push     = |gnt;

    // rst gates the enable so no requester sees ready while reset is held.
    crossfile_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .en      (rst && can_push),
        .gnt     (gnt),
        .gnt_idx (win)
    );

    assign bus.req_ready = gnt;
    assign bus.out_valid = !empty;
    assign bus.out_trans = mem_q[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.grant_id  = grant_id_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        count_d    = count_q;
        if (push) begin
            wr_ptr_d   = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            rr_ptr_d   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            grant_id_d = win;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.req_trans[win];
        end
    end

    a_count_max:  assert property (@(posedge clk) disable iff (!rst) count_q <= CW'(DEPTH));
    a_no_under:   assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
    a_onehot_rdy: assert property (@(posedge clk) $onehot0(gnt));
    a_no_ovf:     assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: tb/tb_crossfile_rr_scheduler.sv
module tb_crossfile_rr_scheduler;
    import crossfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    crossfile_rr_scheduler_if #(.NUM_REQ(4), .DEPTH(4)) bus ();

    crossfile_rr_scheduler #(.NUM_REQ(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic transaction_t tr(input logic [3:0] id);
        transaction_t t;
        t.id   = id;
        t.data = {24'hC0FFEE, id};
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] drain_ids [4];
        logic [3:0] alt_ids   [4];
        logic [3:0] s5_head   [6];
        logic [2:0] s5_count  [6];
        drain_ids = '{4'd1, 4'd2, 4'd3, 4'd2};
        alt_ids   = '{4'd3, 4'd1, 4'd3, 4'd1};
        s5_head   = '{4'd8, 4'd9, 4'd9, 4'd10, 4'd10, 4'd11};
        s5_count  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};

        // Reset held 3 cycles with every requester asking.
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_trans[i] = tr(4'(i));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_count", 32'(bus.count), 32'd0);
            chk("rst_empty", 32'(bus.empty), 32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        end

        // Fill: all four valid, consumer stalled.
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_req_ready", 32'(bus.req_ready), 32'(4'b0001 << i));
            tick();
            chk("fill_grant_id", 32'(bus.grant_id), 32'(i));
            chk("fill_count", 32'(bus.count), 32'(i + 1));
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_req_ready_zero", 32'(bus.req_ready), 32'd0);
        chk("fill_out_valid", 32'(bus.out_valid), 32'd1);
        chk("fill_head", 32'(bus.out_trans), 32'(tr(4'd0)));

        // Push into full with a simultaneous pop.
        bus.req_valid = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        chk("fullpop_req_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        chk("fullpop_count", 32'(bus.count), 32'd4);
        chk("fullpop_grant_id", 32'(bus.grant_id), 32'd2);
        chk("fullpop_head", 32'(bus.out_trans), 32'(tr(4'd1)));

        // Drain the buffer and confirm order.
        bus.req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            chk("drain_head", 32'(bus.out_trans), 32'(tr(drain_ids[k])));
            tick();
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

        // Two requesters alternate; rr_ptr is 3 after the last grant to 2.
        bus.req_valid = 4'b1010;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("alt_req_ready", 32'(bus.req_ready), 32'(4'b0001 << alt_ids[k]));
            tick();
            chk("alt_grant_id", 32'(bus.grant_id), 32'(alt_ids[k]));
            chk("alt_head", 32'(bus.out_trans), 32'(tr(alt_ids[k])));
            chk("alt_count", 32'(bus.count), 32'd1);
        end
        bus.req_valid = 4'b0000;
        tick();
        chk("alt_empty", 32'(bus.empty), 32'd1);

        // Six writes with pops on odd steps; both pointers wrap.
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            bus.req_trans[0] = tr(4'(8 + k));
            bus.out_ready    = (k % 2) == 1;
            #1;
            tick();
            chk("wrap_head", 32'(bus.out_trans), 32'(tr(s5_head[k])));
            chk("wrap_count", 32'(bus.count), 32'(s5_count[k]));
        end

        // Reset with three entries held; req0 would lose to req3 without it.
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1001;
        rst = 1'b0;
        #1;
        chk("rst2_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("rst2_count", 32'(bus.count), 32'd0);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_empty", 32'(bus.empty), 32'd1);
        rst = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        chk("post_rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("post_rst_count", 32'(bus.count), 32'd1);
        chk("post_rst_head", 32'(bus.out_trans), 32'(tr(4'd13)));
        chk("post_rst_next_rdy", 32'(bus.req_ready), 32'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
